// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - shared feeder state encoding, ASCII letter bounds and letter test
package enigma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } feeder_state_t;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

endpackage

// File: rtl/rotor_feeder.sv
// rtl/rotor_feeder.sv - one-character-at-a-time feeder between an upstream source, a rotor and a downstream sink
// Build option ROTOR_FEEDER_PASSTHRU_EN: non-letters bypass the rotor instead of being dropped with err.
module rotor_feeder
  import enigma_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic             in_dec,
  output logic             rotor_valid,
  output logic [7:0]       rotor_din,
  output logic             rotor_dec,
  output logic             rotor_en,
  input  logic             rotor_done,
  input  logic [7:0]       rotor_dout,
  output logic             out_valid,
  output logic [7:0]       out_char,
  input  logic             out_ready,
  output logic             err,
  output logic [CNT_W-1:0] char_cnt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  feeder_state_t    state_q;
  feeder_state_t    state_d;
  logic [7:0]       char_q;
  logic             dec_q;
  logic [7:0]       out_char_q;
  logic [TW-1:0]    to_cnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             err_d;
  logic             accept;
  logic             letter_in;

  assign accept    = (state_q == IDLE) && in_valid;
  assign letter_in = is_letter(in_char);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    err_d       = 1'b0;
    in_ready    = 1'b0;
    rotor_valid = 1'b0;
    rotor_en    = 1'b0;
    out_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (letter_in) begin
            state_d = ISSUE;
          end else begin
`ifdef ROTOR_FEEDER_PASSTHRU_EN
            state_d = HOLD;
`else
            err_d   = 1'b1;
`endif
          end
        end
      end
      ISSUE: begin
        rotor_valid = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        // A result on the final allowed cycle still counts; only its absence aborts.
        if (rotor_done) begin
          state_d = HOLD;
        end else begin
          rotor_en = 1'b1;
          if (to_cnt_q == TO_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      char_q     <= 8'h00;
      dec_q      <= 1'b0;
      out_char_q <= 8'h00;
      to_cnt_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      if (accept) begin
        char_q <= in_char;
        dec_q  <= in_dec;
`ifdef ROTOR_FEEDER_PASSTHRU_EN
        if (!letter_in) begin
          out_char_q <= in_char;
        end
`endif
      end
      if (state_q == ISSUE) begin
        to_cnt_q <= '0;
      end else if (state_q == WAIT) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if ((state_q == WAIT) && rotor_done) begin
        out_char_q <= rotor_dout;
      end
      if ((state_q == HOLD) && out_ready) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign rotor_din = char_q;
  assign rotor_dec = dec_q;
  assign out_char  = out_char_q;
  assign err       = err_q;
  assign char_cnt  = cnt_q;

endmodule

// File: tb/tb_rotor_feeder.sv
// tb/tb_rotor_feeder.sv - directed and randomized checks of rotor_feeder against a transaction-level model
module tb_rotor_feeder;

  localparam int TO  = 8;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_char;
  logic          in_dec;
  logic          rotor_valid;
  logic [7:0]    rotor_din;
  logic          rotor_dec;
  logic          rotor_en;
  logic          rotor_done;
  logic [7:0]    rotor_dout;
  logic          out_valid;
  logic [7:0]    out_char;
  logic          out_ready;
  logic          err;
  logic [CW-1:0] char_cnt;

  int compared   = 0;
  int mismatched = 0;
  int model_cnt  = 0;

  rotor_feeder #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_dec(in_dec),
    .rotor_valid(rotor_valid), .rotor_din(rotor_din), .rotor_dec(rotor_dec), .rotor_en(rotor_en),
    .rotor_done(rotor_done), .rotor_dout(rotor_dout),
    .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready),
    .err(err), .char_cnt(char_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; d = WAIT cycles before the rotor answers (d >= TO means it never does in time).
  task automatic run_char(input logic [7:0] ch, input logic dec, input int d,
                          input logic [7:0] dout, input int stall);
    bit         letter;
    bit         ok;
    bit         din_ok;
    bit         hold_ok;
    bit         ended;
    int         en_cnt;
    logic [7:0] exp_char;
    letter = (ch >= 8'h41) && (ch <= 8'h5A);
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_char  = ch;
    in_dec   = dec;
    @(negedge clk);
    in_valid = 1'b0;
    in_char  = 8'($urandom);
    in_dec   = 1'($urandom);
    if (letter) begin
      chk("rotor_valid", rotor_valid, 1);
      chk("rotor_din", rotor_din, ch);
      chk("rotor_dec", rotor_dec, dec);
      chk("issue_in_ready", in_ready, 0);
      @(negedge clk);
      chk("rotor_valid_once", rotor_valid, 0);
      en_cnt = 0;
      din_ok = 1'b1;
      ended  = 1'b0;
      for (int w = 1; w <= 20; w++) begin
        if (out_valid || err) begin
          ended = 1'b1;
          break;
        end
        rotor_done = (w == d + 1);
        rotor_dout = rotor_done ? dout : 8'($urandom);
        #1;
        if (rotor_en) en_cnt++;
        if (rotor_din !== ch || rotor_dec !== dec || in_ready !== 1'b0) din_ok = 1'b0;
        @(negedge clk);
        rotor_done = 1'b0;
      end
      chk("wait_bound", ended, 1);
      chk("wait_din_stable", din_ok, 1);
      ok = (d < TO);
      chk("rotor_en_cycles", en_cnt, ok ? d : TO);
      if (!ok) begin
        chk("timeout_err", err, 1);
        chk("timeout_no_out", out_valid, 0);
        chk("timeout_idle", in_ready, 1);
        @(negedge clk);
        chk("timeout_err_single", err, 0);
        chk("timeout_cnt", char_cnt, model_cnt);
        return;
      end
      chk("out_char", out_char, dout);
      chk("done_err_low", err, 0);
      exp_char = dout;
    end else begin
`ifdef ROTOR_FEEDER_PASSTHRU_EN
      chk("pt_no_rotor", rotor_valid, 0);
      chk("pt_out_char", out_char, ch);
      chk("pt_err", err, 0);
      exp_char = ch;
`else
      chk("drop_err", err, 1);
      chk("drop_no_out", out_valid, 0);
      chk("drop_no_rotor", rotor_valid, 0);
      chk("drop_idle", in_ready, 1);
      @(negedge clk);
      chk("drop_err_single", err, 0);
      chk("drop_cnt", char_cnt, model_cnt);
      return;
`endif
    end
    chk("hold_valid", out_valid, 1);
    hold_ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_char   = 8'h51;
      @(negedge clk);
      if (out_valid !== 1'b1 || out_char !== exp_char || in_ready !== 1'b0) hold_ok = 1'b0;
    end
    if (stall > 0) chk("hold_stable", hold_ok, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_cnt = (model_cnt + 1) % (1 << CW);
    chk("out_valid_drop", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("char_cnt", char_cnt, model_cnt);
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rotor_valid", rotor_valid, 0);
    chk("rst_rotor_en", rotor_en, 0);
    chk("rst_rotor_din", rotor_din, 0);
    chk("rst_rotor_dec", rotor_dec, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 0);
    chk("rst_err", err, 0);
    chk("rst_char_cnt", char_cnt, 0);
  endtask

  task automatic reset_mid(input bit in_hold);
    in_valid = 1'b1;
    in_char  = 8'h4D;
    in_dec   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    if (in_hold) begin
      rotor_done = 1'b1;
      rotor_dout = 8'h55;
      @(negedge clk);
      rotor_done = 1'b0;
      chk("pre_reset_hold", out_valid, 1);
    end else begin
      @(negedge clk);
      chk("pre_reset_wait", rotor_en, 1);
    end
    reset     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b0;
    model_cnt = 0;
    check_reset_values();
    @(negedge clk);
    chk("post_reset_no_err", err, 0);
    chk("post_reset_no_out", out_valid, 0);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_char    = 8'h00;
    in_dec     = 1'b0;
    rotor_done = 1'b0;
    rotor_dout = 8'h00;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values();

    rotor_done = 1'b1;
    rotor_dout = 8'h77;
    repeat (2) @(negedge clk);
    rotor_done = 1'b0;
    chk("idle_done_ignored_out", out_valid, 0);
    chk("idle_done_ignored_rdy", in_ready, 1);
    chk("idle_done_ignored_en", rotor_en, 0);

    run_char(8'h41, 1'b0, 3, 8'h45, 0);
    run_char(8'h43, 1'b1, 2, 8'h58, 5);
    run_char(8'h44, 1'b0, 100, 8'h00, 0);
    run_char(8'h5A, 1'b1, TO - 1, 8'h4B, 1);
    run_char(8'h5B, 1'b0, 0, 8'h00, 0);
    run_char(8'h40, 1'b0, 0, 8'h00, 0);
    run_char(8'h35, 1'b0, 0, 8'h00, 2);
    run_char(8'h41, 1'b0, 0, 8'h52, 0);

    reset_mid(1'b0);
    run_char(8'h42, 1'b0, 4, 8'h4A, 1);
    reset_mid(1'b1);

    for (int i = 0; i < 16; i++) begin
      run_char(8'(8'h41 + i), 1'(i), i % 4, 8'(8'h61 + i), 0);
    end
    chk("cnt_wrap_zero", char_cnt, 0);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] ch;
      if ($urandom_range(0, 9) < 7) ch = 8'(8'h41 + $urandom_range(0, 25));
      else ch = 8'($urandom);
      run_char(ch, 1'($urandom), int'($urandom_range(0, 9)), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
